// File: rtl/and_gate.sv
// and_gate: bitwise AND with combinational and registered outputs, per-bit rise pulses
// and a saturating rise counter on bit 0 of the registered output.
module and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_q,
  output logic [WIDTH-1:0] c_rise,
  output logic [CNT_W-1:0] rise_cnt
);
  logic [WIDTH-1:0] c_q_prev;
  logic             rise_next;
  assign c         = a & b;
  assign c_rise    = c_q & ~c_q_prev;
  // Counter advances on the same edge that raises c_q[0], so it already shows the new count during the pulse.
  assign rise_next = c[0] & ~c_q[0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c_q      <= '0;
      c_q_prev <= '0;
      rise_cnt <= '0;
    end else begin
      c_q      <= c;
      c_q_prev <= c_q;
      if (rise_next && rise_cnt != '1) rise_cnt <= rise_cnt + 1'b1;
    end
endmodule

// File: tb/tb_and_gate.sv
// tb_and_gate: directed checks of a default 1-bit gate and a 4-bit gate with a 2-bit counter.
module tb_and_gate;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       a1, b1, c1, cq1, cr1;
  logic [7:0] rc1;
  logic [3:0] a4, b4, c4, cq4, cr4;
  logic [1:0] rc4;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  and_gate u_dut (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1),
    .c(c1), .c_q(cq1), .c_rise(cr1), .rise_cnt(rc1)
  );

  and_gate #(.WIDTH(4), .CNT_W(2)) u_w (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4),
    .c(c4), .c_q(cq4), .c_rise(cr4), .rise_cnt(rc4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] tt_exp;
    int         sat_exp [5];
    tt_exp  = 4'b1000;
    sat_exp = '{1, 2, 3, 3, 3};
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a4 = '0; b4 = '0;
    #1;
    chk("reset_cq", {31'd0, cq1}, 32'd0);
    chk("reset_rise", {31'd0, cr1}, 32'd0);
    chk("reset_cnt", {24'd0, rc1}, 32'd0);
    chk("reset_cq_w", {28'd0, cq4}, 32'd0);
    // Truth table while held in reset: c must not care about clk or rst_n.
    for (int i = 0; i < 4; i++) begin
      a1 = i[1]; b1 = i[0];
      #1;
      chk($sformatf("truth_%0d", i), {31'd0, c1}, {31'd0, tt_exp[i]});
      #9;
    end
    a1 = 1'b0; b1 = 1'b0;
    // Release with inputs already high.
    @(negedge clk);
    rst_n = 1'b1; a1 = 1'b1; b1 = 1'b1;
    @(negedge clk);
    chk("release_cq", {31'd0, cq1}, 32'd1);
    chk("release_rise", {31'd0, cr1}, 32'd1);
    chk("release_cnt", {24'd0, rc1}, 32'd1);
    @(negedge clk);
    chk("hold_cq", {31'd0, cq1}, 32'd1);
    chk("hold_rise", {31'd0, cr1}, 32'd0);
    chk("hold_cnt", {24'd0, rc1}, 32'd1);
    a1 = 1'b0;
    @(negedge clk);
    chk("fall_cq", {31'd0, cq1}, 32'd0);
    chk("fall_rise", {31'd0, cr1}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      a1 = 1'b1;
      @(negedge clk);
      a1 = 1'b0;
      @(negedge clk);
    end
    a1 = 1'b1;
    @(negedge clk);
    chk("pre_reset_cq", {31'd0, cq1}, 32'd1);
    chk("pre_reset_cnt", {24'd0, rc1}, 32'd5);
    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    chk("async_cq", {31'd0, cq1}, 32'd0);
    chk("async_cnt", {24'd0, rc1}, 32'd0);
    chk("async_rise", {31'd0, cr1}, 32'd0);
    chk("async_c_high", {31'd0, c1}, 32'd1);
    b1 = 1'b0;
    #1;
    chk("async_c_low", {31'd0, c1}, 32'd0);
    // Width check on the 4-bit instance.
    @(negedge clk);
    rst_n = 1'b1; a1 = 1'b0; a4 = 4'b1100; b4 = 4'b1010;
    #1;
    chk("w_c", {28'd0, c4}, 32'h8);
    @(negedge clk);
    chk("w_cq", {28'd0, cq4}, 32'h8);
    chk("w_rise", {28'd0, cr4}, 32'h8);
    chk("w_cnt", {30'd0, rc4}, 32'd0);
    // Saturation of the 2-bit counter.
    for (int k = 0; k < 5; k++) begin
      a4 = 4'b0001; b4 = 4'b0001;
      @(negedge clk);
      chk($sformatf("sat_cnt_%0d", k), {30'd0, rc4}, sat_exp[k]);
      chk($sformatf("sat_rise_%0d", k), {28'd0, cr4}, 32'h1);
      a4 = 4'b0000;
      @(negedge clk);
    end
    chk("sat_final_cnt", {30'd0, rc4}, 32'd3);
    chk("sat_final_rise", {28'd0, cr4}, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
